// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM encoding and pointer helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PARK  = 2'd2
    } arb_state_e;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]   enc;
    logic [IDX_W:0]     sum;

    // Rotate so ptr lands at bit 0, then the lowest set bit is the winner.
    assign req_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    assign found = |req_rot;
    assign sum   = {1'b0, enc} + {1'b0, ptr};
    assign idx   = (sum >= NumReqW) ? IDX_W'(sum - NumReqW) : sum[IDX_W-1:0];

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grants and one idle cycle between grants.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of continuous ownership.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("rr_grant_arbiter: NUM_REQ must be in 2..16");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_grant_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]    gnt_id_q, gnt_id_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic               pick_found;
    logic [IdxW-1:0]    pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            // ptr already points past the previous owner when PARK is entered.
            IDLE, PARK: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    gnt_d    = NUM_REQ'(1) << pick_idx;
                    gnt_id_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
`endif
                if (!req[gnt_id_q]) begin
                    state_d = PARK;
                    gnt_d   = '0;
                    ptr_d   = IdxW'(rr_next(32'(gnt_id_q), NUM_REQ));
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HoldMax) begin
                    state_d   = PARK;
                    gnt_d     = '0;
                    ptr_d     = IdxW'(rr_next(32'(gnt_id_q), NUM_REQ));
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = |gnt_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed request vectors, per-cycle expected grants.
module tb_rr_grant_arbiter;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req     = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic       to;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    rr_grant_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic push(input logic [3:0] g, input logic t, input string name);
        exp_t e;
        e.gnt  = g;
        e.to   = t;
        e.name = name;
        sb.push_back(e);
    endtask

    // Drive req for the coming edge and record what the DUT must show after it.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic t,
                        input string name);
        @(negedge clock);
        req = r;
        push(g, t, name);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".gnt"}, int'(gnt), int'(e.gnt));
                check({e.name, ".busy"}, int'(busy), int'(|e.gnt));
                check({e.name, ".timeout"}, int'(timeout), int'(e.to));
                if (e.gnt != 4'b0000) begin
                    check({e.name, ".gnt_id"}, int'(gnt_id), oh_idx(e.gnt));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        req     = 4'b1111;
        reset_n = 1'b0;
        #12;
        check("reset.gnt", int'(gnt), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.timeout", int'(timeout), 0);
        check("reset.gnt_id", int'(gnt_id), 0);

        @(negedge clock);
        #1;
        reset_n = 1'b1;
        push(4'b0001, 1'b0, "first_grant");

        // Each owner holds 3 cycles, drops for one edge, then re-raises.
        for (int a = 0; a < 4; a++) begin
            repeat (2) step(4'b1111, 4'b0001 << a, 1'b0, "rr_hold");
            step(4'b1111 & ~(4'b0001 << a), 4'b0000, 1'b0, "rr_release");
            step(4'b1111, 4'b0001 << ((a + 1) % 4), 1'b0, "rr_next_grant");
        end

        step(4'b0000, 4'b0000, 1'b0, "drop_park");
        step(4'b0000, 4'b0000, 1'b0, "drop_idle");
        repeat (5) step(4'b0100, 4'b0100, 1'b0, "single_hold");
        step(4'b0000, 4'b0000, 1'b0, "single_park");
        step(4'b0000, 4'b0000, 1'b0, "single_idle");

        // ptr is now 3: agent0 wins over agent2 by wrapping.
        step(4'b0101, 4'b0001, 1'b0, "wrap_pick");
        step(4'b0000, 4'b0000, 1'b0, "wrap_park");
        step(4'b0001, 4'b0001, 1'b0, "sole_regrant");
        step(4'b0000, 4'b0000, 1'b0, "sole_park");
        step(4'b0000, 4'b0000, 1'b0, "sole_idle");

        step(4'b1000, 4'b1000, 1'b0, "pre_reset_grant");
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset.gnt", int'(gnt), 0);
        check("async_reset.busy", int'(busy), 0);
        req = 4'b0011;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        push(4'b0001, 1'b0, "post_reset_grant");

`ifdef ARB_TIMEOUT_EN
        repeat (15) step(4'b0011, 4'b0001, 1'b0, "to_hold");
        step(4'b0011, 4'b0000, 1'b1, "to_pulse");
        step(4'b0011, 4'b0010, 1'b0, "to_next_owner");
        step(4'b0000, 4'b0000, 1'b0, "to_park");
        step(4'b0000, 4'b0000, 1'b0, "to_idle");
        step(4'b0100, 4'b0100, 1'b0, "solo_grant");
        repeat (15) step(4'b0100, 4'b0100, 1'b0, "solo_hold");
        step(4'b0100, 4'b0000, 1'b1, "solo_timeout");
        step(4'b0100, 4'b0100, 1'b0, "solo_regrant");
        repeat (15) step(4'b0100, 4'b0100, 1'b0, "limit_hold");
        step(4'b0000, 4'b0000, 1'b0, "release_at_limit");
        step(4'b0000, 4'b0000, 1'b0, "limit_idle");
`else
        repeat (20) step(4'b0011, 4'b0001, 1'b0, "hold_forever");
        step(4'b0000, 4'b0000, 1'b0, "hold_park");
        step(4'b0000, 4'b0000, 1'b0, "hold_idle");
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #3;
        check("scoreboard_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
